bus_transfer_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared internal bus that feeds the general-purpose register bank. Up to NUM_REQ requesters, such as the control unit, interrupt logic or debug port, each ask for a register-to-register move (src → dst). The block grants one requester at a time and drives the bank's one-hot bus-select (Rout) and register-enable (Rin) lines through a fixed two-cycle DRIVE/LATCH sequence. Each register latches the bus on the clock edge where its enable is high.

---
 rtl/bus_transfer_arbiter_if.sv | 28 ++
 rtl/bus_transfer_arbiter.sv | 149 ++++++++++++++
 tb/tb_bus_transfer_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_transfer_arbiter_if.sv
// Bus-transfer arbiter bundle: requester side drives req/indices/hold,
// arbiter side drives grant and the register-bank select lines.
interface bus_transfer_arbiter_if #(
   parameter int NUM_REQ  = 4,
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = 4
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*IDX_W-1:0] req_src;
   logic [NUM_REQ*IDX_W-1:0] req_dst;
   logic                     hold;
   logic [NUM_REQ-1:0]       grant;
   logic [NUM_REGS-1:0]      rout;
   logic [NUM_REGS-1:0]      rin;
   logic                     ack;
   logic                     err;
   logic                     busy;

   modport master (
      output req, req_src, req_dst, hold,
      input  grant, rout, rin, ack, err, busy
   );

   modport slave (
      input  req, req_src, req_dst, hold,
      output grant, rout, rin, ack, err, busy
   );
endinterface

// File: rtl/bus_transfer_arbiter.sv
// Round-robin arbiter sequencing register-to-register moves on the
// shared bank bus through a two-cycle DRIVE/LATCH transfer.
module bus_transfer_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = 4
) (
   input logic                  clock,
   input logic                  clear,
   bus_transfer_arbiter_if.slave bus
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      LATCH
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       last_q, last_d;
   logic [IDX_W-1:0]    src_q, src_d;
   logic [IDX_W-1:0]    dst_q, dst_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [NUM_REGS-1:0] rout_q, rout_d;
   logic [NUM_REGS-1:0] rin_q, rin_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;

   logic [NUM_REQ-1:0]  cand;
   logic                win_ok;
   logic [PW-1:0]       win_idx;
   logic [IDX_W-1:0]    win_src;
   logic [IDX_W-1:0]    win_dst;

   function automatic logic in_range(input logic [IDX_W-1:0] i);
      return 32'(i) < 32'(NUM_REGS);
   endfunction

   function automatic logic [NUM_REGS-1:0] sel(input logic [IDX_W-1:0] i);
      logic [NUM_REGS-1:0] v;
      v = '0;
      if (in_range(i)) v = NUM_REGS'(1) << i;
      return v;
   endfunction

   // The owner is masked only while it is finishing in LATCH.
   always_comb begin
      cand = bus.req;
      if (state_q == LATCH) cand = bus.req & ~grant_q;
   end

   always_comb begin
      int idx;
      win_ok  = 1'b0;
      win_idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last_q) + k) % NUM_REQ;
         if (cand[idx]) begin
            win_ok  = 1'b1;
            win_idx = PW'(idx);
         end
      end
   end

   always_comb begin
      win_src = bus.req_src[int'(win_idx)*IDX_W +: IDX_W];
      win_dst = bus.req_dst[int'(win_idx)*IDX_W +: IDX_W];
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      src_d   = src_q;
      dst_d   = dst_q;
      grant_d = grant_q;
      rout_d  = rout_q;
      rin_d   = '0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      busy_d  = busy_q;
      unique case (state_q)
         IDLE, LATCH: begin
            if (!bus.hold && win_ok) begin
               state_d = DRIVE;
               last_d  = win_idx;
               src_d   = win_src;
               dst_d   = win_dst;
               grant_d = NUM_REQ'(1) << win_idx;
               rout_d  = sel(win_src);
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
               grant_d = '0;
               rout_d  = '0;
               busy_d  = 1'b0;
            end
         end
         DRIVE: begin
            state_d = LATCH;
            rin_d   = sel(dst_q);
            ack_d   = 1'b1;
            err_d   = !in_range(src_q) || !in_range(dst_q);
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            rout_d  = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= IDLE;
         last_q  <= PW'(NUM_REQ - 1);
         src_q   <= '0;
         dst_q   <= '0;
         grant_q <= '0;
         rout_q  <= '0;
         rin_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         grant_q <= grant_d;
         rout_q  <= rout_d;
         rin_q   <= rin_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.grant = grant_q;
   assign bus.rout  = rout_q;
   assign bus.rin   = rin_q;
   assign bus.ack   = ack_q;
   assign bus.err   = err_q;
   assign bus.busy  = busy_q;

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Bench for bus_transfer_arbiter: directed scenarios plus random traffic
// against a transaction-level model and a small register bank.
module tb_bus_transfer_arbiter;

   localparam int NR = 4;
   localparam int NG = 12;
   localparam int IW = 4;

   logic clock;
   logic clear;

   bus_transfer_arbiter_if #(.NUM_REQ(NR), .NUM_REGS(NG), .IDX_W(IW)) bus ();

   bus_transfer_arbiter #(.NUM_REQ(NR), .NUM_REGS(NG), .IDX_W(IW)) dut (
      .clock(clock),
      .clear(clear),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [31:0] bank [NG];
   logic [31:0] busv;
   logic        pre_en;
   int          pre_idx;
   logic [31:0] pre_val;

   always_comb begin
      busv = '0;
      for (int i = 0; i < NG; i++)
         if (bus.rout[i]) busv = busv | bank[i];
   end

   always @(posedge clock) begin
      if (pre_en) bank[pre_idx] <= pre_val;
      else
         for (int i = 0; i < NG; i++)
            if (bus.rin[i]) bank[i] <= busv;
   end

   int total;
   int bad;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
      end
   endtask

   // model: phase 0 idle, 1 drive, 2 latch
   int m_phase;
   int m_own;
   int m_src;
   int m_dst;
   int m_last;

   task automatic model_reset();
      m_phase = 0;
      m_last  = NR - 1;
   endtask

   task automatic model_step();
      logic [NR-1:0] r;
      int w;
      int i;
      if (m_phase == 1) begin
         m_phase = 2;
      end else begin
         r = bus.req;
         if (m_phase == 2) r[m_own] = 1'b0;
         w = -1;
         for (int k = 1; k <= NR; k++) begin
            i = (m_last + k) % NR;
            if (w < 0 && r[i]) w = i;
         end
         if (!bus.hold && w >= 0) begin
            m_own   = w;
            m_last  = w;
            m_src   = int'(bus.req_src[w*IW +: IW]);
            m_dst   = int'(bus.req_dst[w*IW +: IW]);
            m_phase = 1;
         end else begin
            m_phase = 0;
         end
      end
   endtask

   task automatic check_outputs();
      logic [31:0] eg, er, ei;
      eg = '0;
      er = '0;
      ei = '0;
      if (m_phase != 0) begin
         eg = 32'(1) << m_own;
         if (m_src < NG) er = 32'(1) << m_src;
      end
      if (m_phase == 2 && m_dst < NG) ei = 32'(1) << m_dst;
      chk("grant", 32'(bus.grant), eg);
      chk("rout", 32'(bus.rout), er);
      chk("rin", 32'(bus.rin), ei);
      chk("ack", 32'(bus.ack), 32'(m_phase == 2));
      chk("err", 32'(bus.err),
          32'(m_phase == 2 && (m_src >= NG || m_dst >= NG)));
      chk("busy", 32'(bus.busy), 32'(m_phase != 0));
   endtask

   task automatic step();
      @(posedge clock);
      if (clear) model_step();
      @(negedge clock);
      check_outputs();
   endtask

   task automatic set_req(input int i, input int s, input int d);
      bus.req_src[i*IW +: IW] = IW'(s);
      bus.req_dst[i*IW +: IW] = IW'(d);
   endtask

   task automatic async_reset();
      #2 clear = 1'b0;
      #1;
      chk("rst_grant", 32'(bus.grant), 0);
      chk("rst_rout", 32'(bus.rout), 0);
      chk("rst_rin", 32'(bus.rin), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      model_reset();
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      clear   = 1'b0;
      bus.req = '0;
      bus.req_src = '0;
      bus.req_dst = '0;
      bus.hold = 1'b0;
      pre_en  = 1'b0;
      pre_idx = 0;
      pre_val = '0;
      model_reset();
      repeat (2) @(negedge clock);
      check_outputs();
      clear = 1'b1;

      // preload R3, then a single transfer 3 -> 7
      pre_en  = 1'b1;
      pre_idx = 3;
      pre_val = 32'hDEADBEEF;
      step();
      pre_en = 1'b0;
      set_req(0, 3, 7);
      bus.req = 4'b0001;
      step();
      step();
      bus.req = 4'b0000;
      step();
      chk("r7", bank[7], 32'hDEADBEEF);

      // all requesting: rotation
      for (int i = 0; i < NR; i++) set_req(i, i, i + 4);
      bus.req = 4'b1111;
      repeat (10) step();
      bus.req = 4'b0000;
      repeat (3) step();

      // index freeze
      set_req(2, 1, 2);
      bus.req = 4'b0100;
      step();
      set_req(2, 1, 5);
      step();
      chk("frz_rin", 32'(bus.rin), 32'h4);
      bus.req = 4'b0000;
      repeat (2) step();

      // hold during DRIVE
      set_req(0, 1, 2);
      set_req(1, 2, 3);
      bus.req = 4'b0011;
      step();
      bus.hold = 1'b1;
      repeat (4) step();
      chk("hold_idle", 32'(bus.busy), 0);
      bus.hold = 1'b0;
      step();
      chk("hold_next", 32'(bus.grant), 32'h2);
      bus.req = 4'b0000;
      repeat (3) step();

      // out of range source
      set_req(0, 13, 4);
      bus.req = 4'b0001;
      step();
      step();
      chk("oor_err", 32'(bus.err), 1);
      bus.req = 4'b0000;
      repeat (2) step();

      // async reset mid-DRIVE
      set_req(0, 2, 3);
      set_req(3, 5, 6);
      bus.req = 4'b0001;
      step();
      async_reset();
      repeat (2) step();
      clear = 1'b1;
      bus.req = 4'b1000;
      step();
      chk("rr_g3", 32'(bus.grant), 32'h8);
      step();
      bus.req = 4'b1001;
      step();
      chk("rr_g0", 32'(bus.grant), 32'h1);
      repeat (5) step();
      bus.req = 4'b0000;
      repeat (3) step();

      // random traffic
      for (int n = 0; n < 800; n++) begin
         bus.req  = NR'($urandom);
         bus.hold = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) == 0) begin
            bus.req_src = 16'($urandom);
            bus.req_dst = 16'($urandom);
         end
         if ($urandom_range(0, 99) == 0) begin
            async_reset();
            step();
            clear = 1'b1;
         end else begin
            step();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
